// File: rtl/vx_fpu_tag_tracker.sv
// vx_fpu_tag_tracker
//   Tracks in-flight FPU requests by tag. Each accepted request is given the
//   lowest free slot; its warp id, packet markers and metadata are parked in
//   that slot until the FPU core answers with the same tag (in any order).
//   The response is merged with the parked fields and committed downstream.
//   Exception flags of multi-packet instructions are OR-accumulated per warp
//   and written to the fflags CSR when the last packet (eop) retires.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       request from dispatch (in_wid, in_sop, in_eop, in_meta)
//   fpu_valid/fpu_ready     request issue to the FPU core, fpu_tag = allocated slot
//   rsp_valid/rsp_ready     FPU response (rsp_tag, rsp_data, rsp_has_fflags, rsp_fflags)
//   out_valid/out_ready     commit (out_wid, out_sop, out_eop, out_meta, out_data)
//   csr_wr_en               fflags CSR write (csr_wr_wid, csr_wr_fflags)
//   pending                 number of outstanding tags
module vx_fpu_tag_tracker #(
  parameter int NUM_WARPS  = 4,
  parameter int QUEUE_SIZE = 8,
  parameter int META_W     = 32,
  parameter int DATA_W     = 128,
  parameter int OUT_REG    = 1,
  localparam int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int TAG_W     = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1,
  localparam int CNT_W     = $clog2(QUEUE_SIZE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WID_W-1:0]  in_wid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [META_W-1:0] in_meta,
  output logic              fpu_valid,
  input  logic              fpu_ready,
  output logic [TAG_W-1:0]  fpu_tag,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_has_fflags,
  input  logic [4:0]        rsp_fflags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WID_W-1:0]  out_wid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [META_W-1:0] out_meta,
  output logic [DATA_W-1:0] out_data,
  output logic              csr_wr_en,
  output logic [WID_W-1:0]  csr_wr_wid,
  output logic [4:0]        csr_wr_fflags,
  output logic [CNT_W-1:0]  pending
);

  logic [QUEUE_SIZE-1:0] busy;
  logic                  full;
  logic [TAG_W-1:0]      free_tag;
  logic                  alloc;
  logic                  rel;
  logic [QUEUE_SIZE-1:0] alloc_mask;
  logic [QUEUE_SIZE-1:0] rel_mask;

  logic [WID_W-1:0]      wid_mem  [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] sop_mem;
  logic [QUEUE_SIZE-1:0] eop_mem;
  logic [META_W-1:0]     meta_mem [QUEUE_SIZE];

  logic [WID_W-1:0]      rd_wid;
  logic                  rd_sop;
  logic                  rd_eop;
  logic [META_W-1:0]     rd_meta;

  logic [4:0]            acc [NUM_WARPS];
  logic [4:0]            acc_cur;
  logic [4:0]            rsp_flags;
  logic [4:0]            merged_flags;

  // Full is derived from registered state only, so a slot released this
  // cycle cannot be handed out again until the next cycle.
  assign full = &busy;

  always_comb begin
    free_tag = '0;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_tag = TAG_W'(i);
    end
  end

  assign fpu_tag   = free_tag;
  assign fpu_valid = in_valid && !full;
  assign in_ready  = fpu_ready && !full;
  assign alloc     = in_valid && in_ready;
  assign rel       = rsp_valid && rsp_ready;

  assign alloc_mask = alloc ? (QUEUE_SIZE'(1) << free_tag) : '0;
  assign rel_mask   = rel   ? (QUEUE_SIZE'(1) << rsp_tag)  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy <= (busy & ~rel_mask) | alloc_mask;
      case ({alloc, rel})
        2'b10:   pending <= pending + CNT_W'(1);
        2'b01:   pending <= pending - CNT_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Per-slot request fields; contents are meaningless while a slot is free.
  always_ff @(posedge clk) begin
    if (alloc) begin
      wid_mem[free_tag]  <= in_wid;
      sop_mem[free_tag]  <= in_sop;
      eop_mem[free_tag]  <= in_eop;
      meta_mem[free_tag] <= in_meta;
    end
  end

  assign rd_wid  = wid_mem[rsp_tag];
  assign rd_sop  = sop_mem[rsp_tag];
  assign rd_eop  = eop_mem[rsp_tag];
  assign rd_meta = meta_mem[rsp_tag];

  // Flags accumulate per warp so partial packets of interleaved warps
  // never contaminate each other; the eop packet flushes and clears.
  assign rsp_flags    = rsp_has_fflags ? rsp_fflags : 5'd0;
  assign acc_cur      = acc[rd_wid];
  assign merged_flags = acc_cur | rsp_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) acc[w] <= '0;
    end else if (rel) begin
      acc[rd_wid] <= rd_eop ? 5'd0 : merged_flags;
    end
  end

  assign csr_wr_en     = rel && rd_eop && (rsp_has_fflags || (acc_cur != 5'd0));
  assign csr_wr_wid    = rd_wid;
  assign csr_wr_fflags = merged_flags;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              vld_p1;
      logic [WID_W-1:0]  wid_p1;
      logic              sop_p1;
      logic              eop_p1;
      logic [META_W-1:0] meta_p1;
      logic [DATA_W-1:0] data_p1;

      // Stage p0 -> p1: the register accepts a new response whenever it is
      // empty or being drained, giving one result per cycle.
      assign rsp_ready = out_ready || !vld_p1;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1 <= 1'b0;
        end else if (rel) begin
          vld_p1 <= 1'b1;
        end else if (out_ready) begin
          vld_p1 <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rel) begin
          wid_p1  <= rd_wid;
          sop_p1  <= rd_sop;
          eop_p1  <= rd_eop;
          meta_p1 <= rd_meta;
          data_p1 <= rsp_data;
        end
      end

      assign out_valid = vld_p1;
      assign out_wid   = wid_p1;
      assign out_sop   = sop_p1;
      assign out_eop   = eop_p1;
      assign out_meta  = meta_p1;
      assign out_data  = data_p1;
    end else begin : g_out_comb
      assign rsp_ready = out_ready;
      assign out_valid = rsp_valid;
      assign out_wid   = rd_wid;
      assign out_sop   = rd_sop;
      assign out_eop   = rd_eop;
      assign out_meta  = rd_meta;
      assign out_data  = rsp_data;
    end
  endgenerate

  // A response for a tag that was never issued is a protocol violation.
  always_ff @(posedge clk) begin
    if (!reset && rsp_valid) begin
      assert (busy[rsp_tag]);
    end
  end

endmodule
